cpu_control_pc: RTL and testbench

Program counter and instruction-decode control stage of the 8-bit single-cycle processor, directly upstream of the register file. Each cycle it takes the 32-bit instruction fetched at `PC`, drives the register file's write/read addresses, write enable and immediate, selects the ALU operation, and computes the next `PC` (sequential, jump or taken branch). It also stalls on data-memory busy and halts on an illegal opcode.

---
 rtl/cpu_pkg.sv | 86 ++++++++
 rtl/pc_next_calc.sv | 23 ++
 rtl/cpu_control_pc.sv | 95 +++++++++
 tb/tb_cpu_control_pc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit single-cycle core.
// Opcodes, ALU ops, control FSM states, field positions, decoder.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int DST_HI = 23;
  localparam int DST_LO = 16;
  localparam int RR1_LO = 8;
  localparam int RR2_LO = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    ALU_FWD = 3'd0,
    ALU_ADD = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } aluop_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic   legal;
    logic   we;
    logic   immsel;
    logic   negsel;
    aluop_e aluop;
    logic   is_j;
    logic   is_beq;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d = '{legal: 1'b1, we: 1'b0, immsel: 1'b0,
          negsel: 1'b0, aluop: ALU_FWD,
          is_j: 1'b0, is_beq: 1'b0};
    unique case (1'b1)
      (op == OP_LOADI): begin
        d.we     = 1'b1;
        d.immsel = 1'b1;
      end
      (op == OP_MOV): d.we = 1'b1;
      (op == OP_ADD): begin
        d.we    = 1'b1;
        d.aluop = ALU_ADD;
      end
      (op == OP_SUB): begin
        d.we     = 1'b1;
        d.negsel = 1'b1;
        d.aluop  = ALU_ADD;
      end
      (op == OP_AND): begin
        d.we    = 1'b1;
        d.aluop = ALU_AND;
      end
      (op == OP_OR): begin
        d.we    = 1'b1;
        d.aluop = ALU_OR;
      end
      (op == OP_J): d.is_j = 1'b1;
      (op == OP_BEQ): begin
        d.is_beq = 1'b1;
        d.negsel = 1'b1;
        d.aluop  = ALU_ADD;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: PC+4, or PC+4 + (sext(off) << 2) on j / taken beq.
// In: i_pc, i_off, i_is_j, i_is_beq, i_zero. Out: o_next_pc.
module pc_next_calc #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [7:0]      i_off,
  input  logic            i_is_j,
  input  logic            i_is_beq,
  input  logic            i_zero,
  output logic [PC_W-1:0] o_next_pc
);

  logic [PC_W-1:0] w_pc4;
  logic [PC_W-1:0] w_off_ext;
  logic            w_taken;

  assign w_pc4     = i_pc + PC_W'(4);
  assign w_off_ext = {{(PC_W-10){i_off[7]}}, i_off, 2'b00};
  assign w_taken   = i_is_j | (i_is_beq & i_zero);
  assign o_next_pc = w_taken ? w_pc4 + w_off_ext : w_pc4;

endmodule

// File: rtl/cpu_control_pc.sv
// PC register, control FSM and instruction decode of the single-cycle core.
// In: CLK, RESET, INSTRUCTION, ZERO, BUSYWAIT. Out: PC, reg addrs, WE, ALU ctl, HALTED.
module cpu_control_pc
  import cpu_pkg::*;
#(
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] RST_VEC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTRUCTION,
  input  logic            ZERO,
  input  logic            BUSYWAIT,
  output logic [PC_W-1:0] PC,
  output logic [2:0]      WRITEREG,
  output logic [2:0]      READREG1,
  output logic [2:0]      READREG2,
  output logic            WRITEENABLE,
  output logic [7:0]      IMMEDIATE,
  output logic            IMMSEL,
  output logic            NEGSEL,
  output logic [2:0]      ALUOP,
  output logic            HALTED
);

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_halted;

  logic [7:0]      w_op;
  dec_t            w_dec;
  logic            w_adv;
  logic [PC_W-1:0] w_pc_next;
  logic            w_unused;

  assign w_op  = INSTRUCTION[OPC_HI:OPC_LO];
  assign w_dec = decode(w_op);

  // source1 only needs 3 of its 8 bits
  assign w_unused = ^INSTRUCTION[15:11];

  assign WRITEREG  = INSTRUCTION[DST_LO+2:DST_LO];
  assign READREG1  = INSTRUCTION[RR1_LO+2:RR1_LO];
  assign READREG2  = INSTRUCTION[RR2_LO+2:RR2_LO];
  assign IMMEDIATE = INSTRUCTION[IMM_HI:IMM_LO];
  assign IMMSEL    = w_dec.immsel;
  assign NEGSEL    = w_dec.negsel;
  assign ALUOP     = w_dec.aluop;

  // an instruction retires only in RUN with memory ready
  assign w_adv = (r_state == S_RUN) & w_dec.legal & ~BUSYWAIT;

  assign WRITEENABLE = w_dec.we & w_adv & ~RESET;
  assign PC          = r_pc;
  assign HALTED      = r_halted;

  pc_next_calc #(
    .PC_W(PC_W)
  ) u_pc_next (
    .i_pc     (r_pc),
    .i_off    (INSTRUCTION[DST_HI:DST_LO]),
    .i_is_j   (w_dec.is_j),
    .i_is_beq (w_dec.is_beq),
    .i_zero   (ZERO),
    .o_next_pc(w_pc_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_pc     <= RST_VEC;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN: begin
          // illegal opcode beats a concurrent busywait
          if (!w_dec.legal) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (BUSYWAIT) begin
            r_state <= S_STALL;
          end else begin
            r_pc <= w_pc_next;
          end
        end
        // PC held on the release edge; instruction replays in RUN
        S_STALL: if (!BUSYWAIT) r_state <= S_RUN;
        S_HALT:  r_halted <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_pc.sv
// Scoreboard bench for cpu_control_pc.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_cpu_control_pc;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic        BUSYWAIT;
  logic [31:0] PC;
  logic [2:0]  WRITEREG;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic        WRITEENABLE;
  logic [7:0]  IMMEDIATE;
  logic        IMMSEL;
  logic        NEGSEL;
  logic [2:0]  ALUOP;
  logic        HALTED;

  cpu_control_pc dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .INSTRUCTION(INSTRUCTION),
    .ZERO       (ZERO),
    .BUSYWAIT   (BUSYWAIT),
    .PC         (PC),
    .WRITEREG   (WRITEREG),
    .READREG1   (READREG1),
    .READREG2   (READREG2),
    .WRITEENABLE(WRITEENABLE),
    .IMMEDIATE  (IMMEDIATE),
    .IMMSEL     (IMMSEL),
    .NEGSEL     (NEGSEL),
    .ALUOP      (ALUOP),
    .HALTED     (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        we;
    logic        hlt;
    bit          dec;
    logic [2:0]  wr;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [7:0]  imm;
    logic        is;
    logic        ns;
    logic [2:0]  op;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  localparam logic [31:0] LD   = 32'h0002005F;
  localparam logic [31:0] MOV  = 32'h01010200;
  localparam logic [31:0] ADD  = 32'h02030102;
  localparam logic [31:0] SUB  = 32'h03040102;
  localparam logic [31:0] ANDI = 32'h04050102;
  localparam logic [31:0] ORI  = 32'h05060102;
  localparam logic [31:0] J0   = 32'h06000000;
  localparam logic [31:0] J80  = 32'h06800000;
  localparam logic [31:0] J7A  = 32'h067A0000;
  localparam logic [31:0] J7F  = 32'h067F0000;
  localparam logic [31:0] BEQ  = 32'h07FE0102;
  localparam logic [31:0] ILL  = 32'h09010102;

  function automatic exp_t mk(input logic [31:0] pc,
                              input logic we, input logic h);
    exp_t e;
    e = '{id: 0, pc: pc, we: we, hlt: h, dec: 1'b0,
          wr: '0, r1: '0, r2: '0, imm: '0,
          is: 1'b0, ns: 1'b0, op: '0};
    return e;
  endfunction

  function automatic exp_t mkd(
    input logic [31:0] pc, input logic we, input logic h,
    input logic [2:0] wr, input logic [2:0] r1,
    input logic [2:0] r2, input logic [7:0] imm,
    input logic is, input logic ns, input logic [2:0] op);
    exp_t e;
    e     = mk(pc, we, h);
    e.dec = 1'b1;
    e.wr  = wr;
    e.r1  = r1;
    e.r2  = r2;
    e.imm = imm;
    e.is  = is;
    e.ns  = ns;
    e.op  = op;
    return e;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL step=%0d %s got=%h exp=%h",
               id, nm, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("PC", e.id, PC, e.pc);
      chk("WRITEENABLE", e.id, 32'(WRITEENABLE), 32'(e.we));
      chk("HALTED", e.id, 32'(HALTED), 32'(e.hlt));
      if (e.dec) begin
        chk("WRITEREG", e.id, 32'(WRITEREG), 32'(e.wr));
        chk("READREG1", e.id, 32'(READREG1), 32'(e.r1));
        chk("READREG2", e.id, 32'(READREG2), 32'(e.r2));
        chk("IMMEDIATE", e.id, 32'(IMMEDIATE), 32'(e.imm));
        chk("IMMSEL", e.id, 32'(IMMSEL), 32'(e.is));
        chk("NEGSEL", e.id, 32'(NEGSEL), 32'(e.ns));
        chk("ALUOP", e.id, 32'(ALUOP), 32'(e.op));
      end
    end
  end

  task automatic step(input logic [31:0] ins, input logic z,
                      input logic b, input logic r,
                      input exp_t e);
    exp_t x;
    INSTRUCTION = ins;
    ZERO        = z;
    BUSYWAIT    = b;
    RESET       = r;
    x    = e;
    x.id = step_id;
    step_id++;
    q.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET       = 1'b1;
    INSTRUCTION = LD;
    ZERO        = 1'b0;
    BUSYWAIT    = 1'b0;
    @(posedge CLK);
    #1;
    // reset held a second edge, then idle, then first instruction
    step(LD, 0, 0, 1, mk(32'h0, 0, 0));
    step(LD, 0, 0, 0, mk(32'h0, 0, 0));
    step(LD, 0, 0, 0,
         mkd(32'h0, 1, 0, 3'd2, 3'd0, 3'd7, 8'd95, 1, 0, 3'd0));
    step(MOV, 0, 0, 0,
         mkd(32'h4, 1, 0, 3'd1, 3'd2, 3'd0, 8'h00, 0, 0, 3'd0));
    // three busy cycles on add at PC=8
    step(ADD, 0, 1, 0,
         mkd(32'h8, 0, 0, 3'd3, 3'd1, 3'd2, 8'h02, 0, 0, 3'd1));
    step(ADD, 0, 1, 0, mk(32'h8, 0, 0));
    step(ADD, 0, 1, 0, mk(32'h8, 0, 0));
    step(ADD, 0, 0, 0, mk(32'h8, 0, 0));
    step(ADD, 0, 0, 0, mk(32'h8, 1, 0));
    // branches around 0x10
    step(J0, 0, 0, 0, mk(32'hC, 0, 0));
    step(BEQ, 1, 0, 0,
         mkd(32'h10, 0, 0, 3'd6, 3'd1, 3'd2, 8'h02, 0, 1, 3'd1));
    step(J0, 0, 0, 0, mk(32'hC, 0, 0));
    step(BEQ, 0, 0, 0, mk(32'h10, 0, 0));
    step(SUB, 0, 0, 0,
         mkd(32'h14, 1, 0, 3'd4, 3'd1, 3'd2, 8'h02, 0, 1, 3'd1));
    step(ANDI, 0, 0, 0,
         mkd(32'h18, 1, 0, 3'd5, 3'd1, 3'd2, 8'h02, 0, 0, 3'd2));
    step(ORI, 0, 0, 0,
         mkd(32'h1C, 1, 0, 3'd6, 3'd1, 3'd2, 8'h02, 0, 0, 3'd3));
    // illegal opcode with busywait: halt wins
    step(ILL, 0, 1, 0,
         mkd(32'h20, 0, 0, 3'd1, 3'd1, 3'd2, 8'h02, 0, 0, 3'd0));
    for (int i = 0; i < 10; i++)
      step(LD, 0, 0, 0, mk(32'h20, 0, 1));
    step(LD, 0, 0, 1, mk(32'h20, 0, 1));
    step(LD, 0, 0, 0, mk(32'h0, 0, 0));
    // jump wrap-around both directions
    step(J80, 0, 0, 0, mk(32'h0, 0, 0));
    step(J7A, 0, 0, 0, mk(32'hFFFF_FE04, 0, 0));
    step(J7F, 0, 0, 0, mk(32'hFFFF_FFF0, 0, 0));
    // reset while stalled
    step(ADD, 0, 1, 0, mk(32'h1F0, 0, 0));
    step(ADD, 0, 1, 1, mk(32'h1F0, 0, 0));
    step(ADD, 0, 1, 0, mk(32'h0, 0, 0));
    step(LD, 0, 0, 0, mk(32'h0, 1, 0));
    step(LD, 0, 1, 0, mk(32'h4, 0, 0));
    repeat (2) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
